ijtag_sib_chain: RTL and testbench

IJTAG_SIB_CHAIN -- requirements
Module: ijtag_sib_chain

---
 rtl/ijtag_sib_chain.sv | 101 ++++++++++
 tb/tb_ijtag_sib_chain.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ijtag_sib_chain.sv
// rtl/ijtag_sib_chain.sv - chain of IJTAG segment insertion bits with lockable client segments
module ijtag_sib_chain #(
    parameter int N_SIB        = 4,
    parameter int CAPTURE_MODE = 0,
    parameter int RETIME_SO    = 1
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_si,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_lock,
    output logic             ijtag_so,
    input  logic [N_SIB-1:0] ijtag_from_so,
    output logic [N_SIB-1:0] ijtag_to_si,
    output logic [N_SIB-1:0] ijtag_to_sel,
    output logic [N_SIB-1:0] sib_open
);

    logic [N_SIB-1:0] sib_q;
    logic [N_SIB-1:0] sib_d;
    logic [N_SIB-1:0] latch_q;
    logic [N_SIB-1:0] latch_d;
    logic [N_SIB-1:0] to_en_q;
    logic [N_SIB-1:0] sib_in;
    logic [N_SIB-1:0] cap_val;

    // Serial input of each SIB: host scan-in for the first, previous SIB otherwise.
    always_comb begin
        sib_in[0] = ijtag_si;
        for (int i = 1; i < N_SIB; i++) begin
            sib_in[i] = sib_q[i-1];
        end
    end

    assign cap_val = (CAPTURE_MODE != 0) ? latch_q : '0;

    // Next SIB flop value: capture beats shift; an open SIB takes its client's scan-out.
    always_comb begin
        sib_d = sib_q;
        if (ijtag_sel && ijtag_ce) begin
            sib_d = cap_val;
        end else if (ijtag_sel && ijtag_se) begin
            sib_d = (latch_q & ijtag_from_so) | (~latch_q & sib_in);
        end
    end

    // Next update-latch value: lock closes regardless of select and overrides update.
    always_comb begin
        latch_d = latch_q;
        if (ijtag_lock) begin
            latch_d = '0;
        end else if (ijtag_sel && ijtag_ue) begin
            latch_d = sib_q;
        end
    end

    // Shift/capture register, rising edge.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            sib_q <= '0;
        end else begin
            sib_q <= sib_d;
        end
    end

    // Update latch and the client enable that trails it by one falling edge.
    always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            latch_q <= '0;
            to_en_q <= '0;
        end else begin
            latch_q <= latch_d;
            to_en_q <= latch_q;
        end
    end

    assign ijtag_to_si  = sib_in;
    assign ijtag_to_sel = to_en_q & {N_SIB{ijtag_sel}};
    assign sib_open     = to_en_q;

    generate
        if (RETIME_SO != 0) begin : g_retime
            logic so_q;
            // Low-phase transparent latch: scan-out moves half a cycle after the rising edge.
            always_latch begin
                if (!ijtag_reset) begin
                    so_q <= 1'b0;
                end else if (!ijtag_tck) begin
                    so_q <= sib_q[N_SIB-1];
                end
            end
            assign ijtag_so = so_q;
        end else begin : g_direct
            assign ijtag_so = sib_q[N_SIB-1];
        end
    endgenerate

endmodule

// File: tb/tb_ijtag_sib_chain.sv
// tb/tb_ijtag_sib_chain.sv - scoreboard bench for ijtag_sib_chain against a scan-path queue model
module tb_ijtag_sib_chain;

    localparam int N  = 4;
    localparam int CL = 3;

    logic tck;
    logic ijtag_reset, sel, si, ce, se, ue, lock;
    logic so0, so1;
    logic [N-1:0] fso0, fso1, tsi0, tsi1, tsel0, tsel1, open0, open1;

    ijtag_sib_chain #(.N_SIB(N), .CAPTURE_MODE(1), .RETIME_SO(1)) u_dut0 (
        .ijtag_tck(tck), .ijtag_reset(ijtag_reset), .ijtag_sel(sel), .ijtag_si(si),
        .ijtag_ce(ce), .ijtag_se(se), .ijtag_ue(ue), .ijtag_lock(lock), .ijtag_so(so0),
        .ijtag_from_so(fso0), .ijtag_to_si(tsi0), .ijtag_to_sel(tsel0), .sib_open(open0));

    ijtag_sib_chain #(.N_SIB(N), .CAPTURE_MODE(0), .RETIME_SO(0)) u_dut1 (
        .ijtag_tck(tck), .ijtag_reset(ijtag_reset), .ijtag_sel(sel), .ijtag_si(si),
        .ijtag_ce(ce), .ijtag_se(se), .ijtag_ue(ue), .ijtag_lock(lock), .ijtag_so(so1),
        .ijtag_from_so(fso1), .ijtag_to_si(tsi1), .ijtag_to_sel(tsel1), .sib_open(open1));

    initial tck = 1'b0;
    always #5 tck = ~tck;

    // Client segments: plain CL-bit shift registers per SIB per DUT.
    logic [CL-1:0] cli [2][N];
    always @(posedge tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            for (int i = 0; i < N; i++) begin
                cli[0][i] <= '0;
                cli[1][i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (tsel0[i] && se && !ce) cli[0][i] <= {cli[0][i][CL-2:0], tsi0[i]};
                if (tsel1[i] && se && !ce) cli[1][i] <= {cli[1][i][CL-2:0], tsi1[i]};
            end
        end
    end
    always_comb begin
        for (int i = 0; i < N; i++) begin
            fso0[i] = cli[0][i][CL-1];
            fso1[i] = cli[1][i][CL-1];
        end
    end

    // Reference model: SIB bits, update latches, enables and client contents per DUT.
    bit m_sib [2][N];
    bit m_lat [2][N];
    bit m_en  [2][N];
    bit m_cli [2][N][CL];

    typedef struct {
        int          dut;
        int          kind;
        logic [31:0] val;
    } exp_t;
    exp_t q_neg[$];
    exp_t q_pos[$];

    int n_chk;
    int n_fail;
    int dir_so [2];
    int dir_open;
    int dir_tosel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++) begin
                m_sib[d][i] = 0;
                m_lat[d][i] = 0;
                m_en[d][i]  = 0;
                for (int k = 0; k < CL; k++) m_cli[d][i][k] = 0;
            end
    endfunction

    // Rising edge: capture, or shift the whole active scan path as one queue.
    function automatic void model_pos(input int d, input bit s, input bit c, input bit h, input bit din);
        bit q[$];
        int p;
        if (s && c) begin
            for (int i = 0; i < N; i++) m_sib[d][i] = (d == 0) ? m_lat[d][i] : 1'b0;
        end else if (s && h) begin
            for (int i = 0; i < N; i++) begin
                if (m_lat[d][i]) for (int k = 0; k < CL; k++) q.push_back(m_cli[d][i][k]);
                q.push_back(m_sib[d][i]);
            end
            q.push_front(din);
            void'(q.pop_back());
            p = 0;
            for (int i = 0; i < N; i++) begin
                if (m_lat[d][i]) for (int k = 0; k < CL; k++) begin m_cli[d][i][k] = q[p]; p++; end
                m_sib[d][i] = q[p];
                p++;
            end
        end
    endfunction

    // Falling edge: enables follow the latches of the previous falling edge.
    function automatic void model_neg(input int d, input bit s, input bit u, input bit l);
        for (int i = 0; i < N; i++) begin
            m_en[d][i] = m_lat[d][i];
            if (l) m_lat[d][i] = 0;
            else if (s && u) m_lat[d][i] = m_sib[d][i];
        end
    endfunction

    function automatic logic [31:0] pack_en(input int d, input bit gate);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i] = m_en[d][i] & gate;
        return r;
    endfunction

    function automatic logic [31:0] obs(input int d, input int k);
        case (k)
            0: return (d == 0) ? {31'd0, so0} : {31'd0, so1};
            1: return (d == 0) ? 32'(open0) : 32'(open1);
            2: return (d == 0) ? 32'(tsel0) : 32'(tsel1);
            default: return {31'd0, so0};
        endcase
    endfunction

    function automatic string kname(input int k);
        case (k)
            0: return "so";
            1: return "sib_open";
            2: return "to_sel";
            default: return "so_hold_after_posedge";
        endcase
    endfunction

    // Monitors: compare DUT outputs against queued expectations.
    initial forever begin
        exp_t e;
        @(negedge tck);
        #2;
        while (q_neg.size() > 0) begin
            e = q_neg.pop_front();
            check($sformatf("dut%0d_%s", e.dut, kname(e.kind)), obs(e.dut, e.kind), e.val);
        end
    end
    initial forever begin
        exp_t e;
        @(posedge tck);
        #1;
        while (q_pos.size() > 0) begin
            e = q_pos.pop_front();
            check($sformatf("dut%0d_%s", e.dut, kname(e.kind)), obs(e.dut, e.kind), e.val);
        end
    end

    // One tck cycle starting at negedge+3: drive, advance model, queue expectations.
    task automatic cycle(input bit s, input bit c, input bit h, input bit u, input bit l, input bit din);
        sel = s; ce = c; se = h; ue = u; lock = l; si = din;
        q_pos.push_back('{0, 3, {31'd0, m_sib[0][N-1]}});
        @(posedge tck);
        if (ijtag_reset) for (int d = 0; d < 2; d++) model_pos(d, s, c, h, din);
        @(negedge tck);
        if (ijtag_reset) for (int d = 0; d < 2; d++) model_neg(d, s, u, l);
        for (int d = 0; d < 2; d++) begin
            q_neg.push_back('{d, 0, {31'd0, m_sib[d][N-1]}});
            q_neg.push_back('{d, 1, pack_en(d, 1'b1)});
            q_neg.push_back('{d, 2, pack_en(d, s)});
            if (dir_so[d] >= 0) q_neg.push_back('{d, 0, 32'(dir_so[d])});
            if (dir_open >= 0) q_neg.push_back('{d, 1, 32'(dir_open)});
            if (dir_tosel >= 0) q_neg.push_back('{d, 2, 32'(dir_tosel)});
        end
        dir_so[0] = -1; dir_so[1] = -1; dir_open = -1; dir_tosel = -1;
        #3;
    endtask

    task automatic idle(input bit s);
        cycle(s, 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic shift(input bit din);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, din);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_fail = 0;
        dir_so[0] = -1; dir_so[1] = -1; dir_open = -1; dir_tosel = -1;
        ijtag_reset = 1'b0; sel = 0; si = 0; ce = 0; se = 0; ue = 0; lock = 0;
        model_reset();
        @(negedge tck); @(negedge tck); #3;
        ijtag_reset = 1'b1;

        // Reset state, all-zero update, scan length 4.
        dir_open = 0; dir_tosel = 0; idle(1'b1);
        for (int k = 0; k < 4; k++) shift(1'b0);
        cycle(1'b1, 0, 0, 1, 0, 0);
        dir_open = 0; dir_tosel = 0; idle(1'b1);
        for (int k = 1; k <= 4; k++) begin
            dir_so[0] = (k == 4) ? 1 : 0; dir_so[1] = dir_so[0];
            shift(k == 1);
        end

        // Open SIB0 and SIB2; enable appears one falling edge after the latch.
        shift(1'b0); shift(1'b1); shift(1'b0); shift(1'b1);
        dir_open = 0; cycle(1'b1, 0, 0, 1, 0, 0);
        dir_open = 5; dir_tosel = 5; idle(1'b1);
        dir_open = 5; dir_tosel = 0; idle(1'b0);

        // Walking one across a 10-bit path.
        for (int k = 0; k < 12; k++) shift(1'b0);
        for (int k = 1; k <= 10; k++) begin
            dir_so[0] = (k == 10) ? 1 : 0; dir_so[1] = dir_so[0];
            shift(k == 1);
        end

        // Capture: latch value in mode 1, zero in mode 0.
        dir_so[0] = 0; dir_so[1] = 0; cycle(1'b1, 1, 0, 0, 0, 0);
        dir_so[0] = 1; dir_so[1] = 0; shift(1'b0);
        for (int k = 0; k < 3; k++) shift(1'b0);

        // Open all, then lock closes and blocks updates.
        for (int k = 0; k < 10; k++) shift(1'b1);
        cycle(1'b1, 0, 0, 1, 0, 0);
        dir_open = 15; idle(1'b1);
        cycle(1'b1, 0, 0, 0, 1, 0);
        dir_open = 0; cycle(1'b1, 0, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) cycle(1'b1, 0, 1, 0, 1, 1);
        cycle(1'b1, 0, 0, 1, 1, 0);
        dir_open = 0; cycle(1'b1, 0, 0, 0, 1, 0);
        idle(1'b1);

        // Reset during the update falling edge with sib=1111.
        sel = 1; ue = 1; ce = 0; se = 0; lock = 0;
        @(posedge tck); @(negedge tck); #1;
        ijtag_reset = 1'b0;
        #1;
        check("reset_so0", {31'd0, so0}, 32'd0);
        check("reset_so1", {31'd0, so1}, 32'd0);
        check("reset_open", 32'({open1, open0}), 32'd0);
        check("reset_tosel", 32'({tsel1, tsel0}), 32'd0);
        model_reset();
        #1;
        idle(1'b1); cycle(1'b1, 0, 0, 1, 0, 0);
        ijtag_reset = 1'b1;
        dir_open = 0; idle(1'b1);
        dir_open = 0; idle(1'b1);

        // Randomized operation mix.
        repeat (80) begin
            case ($urandom_range(0, 6))
                0: repeat ($urandom_range(1, 12)) shift(1'($urandom_range(0, 1)));
                1: begin cycle(1'b1, 0, 0, 1, 0, 0); idle(1'($urandom_range(0, 1))); end
                2: cycle(1'b1, 1, 0, 0, 0, 0);
                3: begin
                    cycle(1'($urandom_range(0, 1)), 0, 0, 1'($urandom_range(0, 1)), 1, 0);
                    idle(1'b1);
                end
                4: cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
                5: begin cycle(1'b1, 1, 1, 1, 0, 1'($urandom_range(0, 1))); idle(1'b1); end
                default: cycle(1'b1, 1, 1, 0, 0, 1'($urandom_range(0, 1)));
            endcase
        end

        idle(1'b1); idle(1'b1);
        @(posedge tck); #2;
        check("scoreboard_drained", 32'(q_neg.size() + q_pos.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
